adaptor2x2_nios2_gen2_10_cpu_debug_mem_sequencer: RTL and testbench
===================================================================

ADAPTOR2X2_NIOS2_GEN2_10_CPU_DEBUG_MEM_SEQUENCER -- requirements
Module: adaptor2x2_nios2_gen2_10_cpu_debug_mem_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk and reset_n.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles before abort.
REQ-003 SHALL have parameter AW, default 8, meaning the memory word-address width.
REQ-004 Port clk, input, 1, system clock.
REQ-005 Port reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port jdo, input, 38, debug-slave data word, valid on the cycle of any take_* pulse.
REQ-007 Port take_action_ocimem_a, input, 1, one-cycle address-load/read command pulse.
REQ-008 Port take_action_ocimem_b, input, 1, one-cycle write command pulse.
REQ-009 Port take_no_action_ocimem_a, input, 1, one-cycle read-next command pulse.
REQ-010 Port mem_req, output, 1, memory request, held until ack.
REQ-011 Port mem_we, output, 1, write qualifier for mem_req.
REQ-012 Port mem_addr, output, AW, word address.
REQ-013 Port mem_wdata, output, 32, write data.
REQ-014 Port mem_rdata, input, 32, read data, valid with mem_ack.
REQ-015 Port mem_ack, input, 1, one-cycle completion.
REQ-016 Port MonDReg, output, 32, last read data.
REQ-017 Port monitor_ready, output, 1, high when IDLE.
REQ-018 Port monitor_error, output, 1, sticky error flag.

Function
REQ-019 SHALL implement the FSM states IDLE, ISSUE, WAIT, DONE; transitions: IDLE->ISSUE on an accepted command, ISSUE->WAIT unconditionally, WAIT->DONE on mem_ack or timeout, DONE->IDLE unconditionally.
REQ-020 take_action_ocimem_a SHALL load addr<=jdo[AW+9:10]; if jdo[35]=1 it SHALL also start a read at the new addr, otherwise it completes with no memory access and the FSM stays IDLE.
REQ-021 take_action_ocimem_b SHALL start a write of jdo[34:3] at addr.
REQ-022 take_no_action_ocimem_a SHALL start a read at addr.
REQ-023 mem_req SHALL assert in ISSUE and hold through WAIT until the mem_ack cycle inclusive; mem_addr, mem_we and mem_wdata SHALL be stable while mem_req=1.
REQ-024 On a read, mem_rdata SHALL be captured into MonDReg on the mem_ack cycle; MonDReg is visible in DONE.
REQ-025 After every completed read or write, addr SHALL increment by 1 modulo 2^AW (wrap 0xFF->0x00 for AW=8).
REQ-026 Command-to-monitor_ready latency SHALL be 3 cycles plus memory latency; an ack on the first WAIT cycle returns to IDLE 4 cycles after the command pulse.
REQ-027 The WAIT counter SHALL abort at TIMEOUT cycles: go to DONE, drop mem_req, set monitor_error, leave MonDReg and addr unchanged.
REQ-028 A take_* pulse while not IDLE SHALL be dropped and SHALL set monitor_error.
REQ-029 Simultaneous take_* pulses in IDLE SHALL be resolved with priority ocimem_b > action_ocimem_a > no_action_ocimem_a; the losers are dropped without error.
REQ-030 monitor_error SHALL clear on the next accepted command; setting and clearing in the same cycle SHALL resolve to set.
REQ-031 mem_ack outside WAIT SHALL be ignored.

Reset
REQ-032 Reset SHALL set the state to IDLE, addr=0, MonDReg=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, monitor_ready=1, monitor_error=0.
REQ-033 Reset asserted mid-transaction SHALL drop mem_req immediately (asynchronously); the outstanding ack after reset release SHALL be ignored.

Structure
REQ-034 State encodings, the opcode bit positions (35, 34:3, AW+9:10) and the TIMEOUT default SHALL reside in the shared package adaptor2x2_nios2_gen2_10_cpu_debug_pkg.
REQ-035 The timeout counter SHALL be a separate sub-module, adaptor2x2_nios2_gen2_10_cpu_debug_wait_timer; the FSM and datapath SHALL be flat.

Verification
REQ-036 action_a with jdo[35]=0 and addr=0x10, then ocimem_b with data 0xDEADBEEF -> write to 0x10, addr becomes 0x11, monitor_ready low for 3+N cycles.
REQ-037 action_a with jdo[35]=1 and addr=0x10, with memory returning 0xDEADBEEF -> MonDReg=0xDEADBEEF, addr becomes 0x11.
REQ-038 addr=0xFF followed by no_action_a -> read at 0xFF, addr wraps to 0x00.
REQ-039 mem_ack withheld -> after 255 WAIT cycles, monitor_error=1 and mem_req=0; the next command clears the error.
REQ-040 A command while in WAIT -> it is dropped and monitor_error=1; ocimem_b and no_action_a in the same cycle -> only the write executes.
REQ-041 reset_n pulsed during WAIT -> all outputs return to reset values, and a late mem_ack causes no change.

Source files
------------

// File: rtl/adaptor2x2_nios2_gen2_10_cpu_debug_pkg.sv
// Shared definitions for the debug memory sequencer: FSM encoding, debug
// word field positions and parameter defaults.
package adaptor2x2_nios2_gen2_10_cpu_debug_pkg;

  localparam int JDO_W           = 38;
  localparam int RD_BIT          = 35;  // action_a: also start a read
  localparam int WDATA_MSB       = 34;  // ocimem_b write data field
  localparam int WDATA_LSB       = 3;
  localparam int ADDR_LSB        = 10;  // action_a address field is [ADDR_LSB +: AW]
  localparam int TIMEOUT_DEFAULT = 255;
  localparam int AW_DEFAULT      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Highest bit of the action_a address field for a given address width.
  function automatic int addr_msb(input int aw);
    return aw + ADDR_LSB - 1;
  endfunction

endpackage

// File: rtl/adaptor2x2_nios2_gen2_10_cpu_debug_mem_sequencer_if.sv
// Memory-side bus of the debug sequencer.
//
// Handshake: the master raises mem_req together with mem_we/mem_addr/mem_wdata
// and holds all four stable until it samples mem_ack high. The slave answers
// with a single-cycle mem_ack; on reads mem_rdata is valid in that same cycle.
// An ack while mem_req is low carries no meaning and is ignored.
interface adaptor2x2_nios2_gen2_10_cpu_debug_mem_sequencer_if #(
  parameter int AW = 8
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/adaptor2x2_nios2_gen2_10_cpu_debug_wait_timer.sv
// Counts consecutive WAIT cycles and flags the last permitted one so the
// sequencer can abandon an unanswered memory request.
module adaptor2x2_nios2_gen2_10_cpu_debug_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic expired
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // expired marks the TIMEOUT-th consecutive cycle of run
  assign expired = run && (count == CW'(TIMEOUT - 1));

  // Cycle counter, cleared whenever the sequencer is not waiting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!run) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/adaptor2x2_nios2_gen2_10_cpu_debug_mem_sequencer.sv
// Debug memory sequencer: turns one-cycle debug command pulses into single
// memory transactions, keeps an auto-incrementing word address, captures read
// data into MonDReg and reports busy/error status to the debug slave.
module adaptor2x2_nios2_gen2_10_cpu_debug_mem_sequencer
  import adaptor2x2_nios2_gen2_10_cpu_debug_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int AW      = AW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [JDO_W-1:0]     jdo,
  input  logic                 take_action_ocimem_a,
  input  logic                 take_action_ocimem_b,
  input  logic                 take_no_action_ocimem_a,
  adaptor2x2_nios2_gen2_10_cpu_debug_mem_sequencer_if.master mem,
  output logic [31:0]          MonDReg,
  output logic                 monitor_ready,
  output logic                 monitor_error,
  output seq_state_t           fsm_state
);

  seq_state_t    state, state_next;
  logic [AW-1:0] addr;
  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic [31:0]   mem_wdata_q;
  logic          error_q;
  logic          expired;

  logic idle, in_wait, any_take;
  logic accept_write, accept_load, accept_read, accept_any;
  logic start, drop, ack_in_wait, abort;
  logic unused_jdo;

  // Bits of the debug word this block has no use for
  assign unused_jdo = ^{jdo[JDO_W-1:RD_BIT+1], jdo[WDATA_LSB-1:0]};

  assign idle     = (state == ST_IDLE);
  assign in_wait  = (state == ST_WAIT);
  assign any_take = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // Only one command wins in IDLE: write, then address load, then read-next.
  assign accept_write = idle & take_action_ocimem_b;
  assign accept_load  = idle & ~take_action_ocimem_b & take_action_ocimem_a;
  assign accept_read  = idle & ~take_action_ocimem_b & ~take_action_ocimem_a
                        & take_no_action_ocimem_a;
  assign accept_any   = accept_write | accept_load | accept_read;

  // An address load without the read bit finishes in IDLE with no memory access.
  assign start = accept_write | accept_read | (accept_load & jdo[RD_BIT]);
  assign drop  = ~idle & any_take;

  // Acks are only meaningful while waiting; an ack on the final timed cycle
  // still completes the transfer rather than aborting it.
  assign ack_in_wait = in_wait & mem.mem_ack;
  assign abort       = in_wait & ~mem.mem_ack & expired;

  adaptor2x2_nios2_gen2_10_cpu_debug_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (in_wait),
    .expired (expired)
  );

  // State register; reset drops straight to IDLE so mem_req falls at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_next    = state;
    mem.mem_req   = 1'b0;
    monitor_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        monitor_ready = 1'b1;
        if (start) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem.mem_req = 1'b1;
        state_next  = ST_WAIT;
      end
      ST_WAIT: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack || expired) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Request fields are loaded only on acceptance, so they hold through WAIT;
  // address advances and read data lands only on a real completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr        <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      MonDReg     <= '0;
    end else begin
      if (accept_write) begin
        mem_we_q    <= 1'b1;
        mem_addr_q  <= addr;
        mem_wdata_q <= jdo[WDATA_MSB:WDATA_LSB];
      end else if (accept_load) begin
        addr <= jdo[addr_msb(AW):ADDR_LSB];
        if (jdo[RD_BIT]) begin
          mem_we_q   <= 1'b0;
          mem_addr_q <= jdo[addr_msb(AW):ADDR_LSB];
        end
      end else if (accept_read) begin
        mem_we_q   <= 1'b0;
        mem_addr_q <= addr;
      end
      if (ack_in_wait) begin
        addr <= addr + AW'(1);
        if (!mem_we_q) MonDReg <= mem.mem_rdata;
      end
    end
  end

  // Sticky error: set by dropped commands and timeouts, cleared by the next
  // accepted command; a set in the same cycle wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error_q <= 1'b0;
    end else if (drop || abort) begin
      error_q <= 1'b1;
    end else if (accept_any) begin
      error_q <= 1'b0;
    end
  end

  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign monitor_error = error_q;
  assign fsm_state     = state;

endmodule

// File: tb/tb_adaptor2x2_nios2_gen2_10_cpu_debug_mem_sequencer.sv
// Directed bench for the debug memory sequencer. A memory responder doubles
// as the request monitor: every request the DUT raises is matched against the
// expected queue filled by the command driver.
module tb_adaptor2x2_nios2_gen2_10_cpu_debug_mem_sequencer;
  import adaptor2x2_nios2_gen2_10_cpu_debug_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  seq_state_t  fsm_state;

  adaptor2x2_nios2_gen2_10_cpu_debug_mem_sequencer_if #(.AW(8)) mem_bus ();

  adaptor2x2_nios2_gen2_10_cpu_debug_mem_sequencer #(.TIMEOUT(255), .AW(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .mem                     (mem_bus),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .fsm_state               (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [40:0] exp_q[$];      // {we, addr[7:0], wdata[31:0]}
  int          n_checks = 0;
  int          n_errors = 0;

  int          ack_delay = 0;  // extra WAIT cycles before ack, -1 = never ack
  logic [31:0] resp_data = '0;
  logic        resp_ack  = 1'b0;
  logic        stray_ack = 1'b0;
  logic        req_prev  = 1'b0;

  assign mem_bus.mem_ack   = resp_ack | stray_ack;
  assign mem_bus.mem_rdata = stray_ack ? 32'hFFFF_FFFF : resp_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] jdo_a(input logic rd, input logic [7:0] a);
    logic [37:0] j;
    j = '0;
    j[35] = rd;
    j[17:10] = a;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic push_exp(input logic we, input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({we, a, d});
  endtask

  // ---------------- memory responder / request monitor ----------------
  initial begin
    logic [40:0] e;
    forever begin
      @(negedge clk);
      if (mem_bus.mem_req && !req_prev) begin
        e = '0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_req: addr %h we %b expected none",
                   mem_bus.mem_addr, mem_bus.mem_we);
        end else begin
          e = exp_q.pop_front();
          check("req_we", {31'b0, mem_bus.mem_we}, {31'b0, e[40]});
          check("req_addr", {24'b0, mem_bus.mem_addr}, {24'b0, e[39:32]});
          if (e[40]) check("req_wdata", mem_bus.mem_wdata, e[31:0]);
        end
        if (ack_delay >= 0) begin
          repeat (ack_delay + 1) @(negedge clk);
          check("req_addr_hold", {24'b0, mem_bus.mem_addr}, {24'b0, e[39:32]});
          check("req_held", {31'b0, mem_bus.mem_req}, 32'd1);
          resp_ack = 1'b1;
          @(negedge clk);
          resp_ack = 1'b0;
        end
      end
      req_prev = mem_bus.mem_req;
    end
  end

  // ---------------- driver tasks ----------------
  // Called on a negedge; returns on the negedge after the pulse was sampled.
  task automatic pulse(input logic b, input logic a, input logic n, input logic [37:0] d);
    take_action_ocimem_b    = b;
    take_action_ocimem_a    = a;
    take_no_action_ocimem_a = n;
    jdo                     = d;
    @(negedge clk);
    take_action_ocimem_b    = 1'b0;
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_idle(output int low);
    low = 0;
    while (!monitor_ready && low < 600) begin
      @(negedge clk);
      low++;
    end
    if (!monitor_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: monitor_ready still 0 after %0d cycles, need 1", low);
    end
  endtask

  task automatic run_cmd(input string name, input logic b, input logic a, input logic n,
                         input logic [37:0] d, input int delay, input logic [31:0] resp,
                         input int exp_low);
    int low;
    ack_delay = delay;
    resp_data = resp;
    pulse(b, a, n, d);
    wait_idle(low);
    check({name, "_latency"}, low, exp_low);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int low;
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // reset values
    check("rst_ready", {31'b0, monitor_ready}, 32'd1);
    check("rst_error", {31'b0, monitor_error}, 32'd0);
    check("rst_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("rst_we", {31'b0, mem_bus.mem_we}, 32'd0);
    check("rst_addr", {24'b0, mem_bus.mem_addr}, 32'd0);
    check("rst_wdata", mem_bus.mem_wdata, 32'd0);
    check("rst_mondreg", MonDReg, 32'd0);
    check("rst_state", {30'b0, fsm_state}, {30'b0, ST_IDLE});

    // address load without read: no memory access, stays IDLE
    run_cmd("load_only", 1'b0, 1'b1, 1'b0, jdo_a(1'b0, 8'h10), 0, 32'h0, 0);
    check("load_only_req", {31'b0, mem_bus.mem_req}, 32'd0);

    // write DEADBEEF at 0x10, immediate ack -> 3 busy cycles
    push_exp(1'b1, 8'h10, 32'hDEAD_BEEF);
    run_cmd("write0", 1'b1, 1'b0, 1'b0, jdo_b(32'hDEAD_BEEF), 0, 32'h0, 3);
    check("write0_error", {31'b0, monitor_error}, 32'd0);

    // write at auto-incremented 0x11 with two extra wait cycles
    push_exp(1'b1, 8'h11, 32'h1234_5678);
    run_cmd("write1", 1'b1, 1'b0, 1'b0, jdo_b(32'h1234_5678), 2, 32'h0, 5);

    // load 0x10 and read
    push_exp(1'b0, 8'h10, 32'h0);
    run_cmd("load_read", 1'b0, 1'b1, 1'b0, jdo_a(1'b1, 8'h10), 0, 32'hDEAD_BEEF, 3);
    check("load_read_data", MonDReg, 32'hDEAD_BEEF);

    // read-next at 0x11
    push_exp(1'b0, 8'h11, 32'h0);
    run_cmd("read_next", 1'b0, 1'b0, 1'b1, '0, 0, 32'hCAFE_F00D, 3);
    check("read_next_data", MonDReg, 32'hCAFE_F00D);

    // wrap: read at 0xFF, then the next read must be at 0x00
    run_cmd("load_ff", 1'b0, 1'b1, 1'b0, jdo_a(1'b0, 8'hFF), 0, 32'h0, 0);
    push_exp(1'b0, 8'hFF, 32'h0);
    run_cmd("read_ff", 1'b0, 1'b0, 1'b1, '0, 0, 32'h0BAD_F00D, 3);
    check("read_ff_data", MonDReg, 32'h0BAD_F00D);
    push_exp(1'b0, 8'h00, 32'h0);
    run_cmd("read_wrap", 1'b0, 1'b0, 1'b1, '0, 0, 32'h1111_2222, 3);
    check("read_wrap_data", MonDReg, 32'h1111_2222);

    // timeout: no ack -> ISSUE + 255 WAIT + DONE busy cycles
    push_exp(1'b0, 8'h01, 32'h0);
    run_cmd("timeout", 1'b0, 1'b0, 1'b1, '0, -1, 32'h0, 257);
    check("timeout_error", {31'b0, monitor_error}, 32'd1);
    check("timeout_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("timeout_mondreg", MonDReg, 32'h1111_2222);

    // next command clears the error; addr was not advanced by the abort
    push_exp(1'b0, 8'h01, 32'h0);
    ack_delay = 1;
    resp_data = 32'h3333_4444;
    pulse(1'b0, 1'b0, 1'b1, '0);
    check("error_clear", {31'b0, monitor_error}, 32'd0);
    wait_idle(low);
    check("after_timeout_latency", low, 4);
    check("after_timeout_data", MonDReg, 32'h3333_4444);

    // command arriving in WAIT is dropped and flags an error
    push_exp(1'b0, 8'h02, 32'h0);
    ack_delay = 4;
    resp_data = 32'h5555_6666;
    pulse(1'b0, 1'b0, 1'b1, '0);
    @(negedge clk);
    check("busy_state", {30'b0, fsm_state}, {30'b0, ST_WAIT});
    pulse(1'b1, 1'b0, 1'b0, jdo_b(32'hBAD0_BAD0));
    wait_idle(low);
    check("drop_error", {31'b0, monitor_error}, 32'd1);
    check("drop_data", MonDReg, 32'h5555_6666);

    // write beats read-next in the same cycle; accepted command clears error
    push_exp(1'b1, 8'h03, 32'hA5A5_5A5A);
    run_cmd("prio_b_n", 1'b1, 1'b0, 1'b1, jdo_b(32'hA5A5_5A5A), 0, 32'h0, 3);
    check("prio_b_n_error", {31'b0, monitor_error}, 32'd0);

    // address load beats read-next
    push_exp(1'b0, 8'h40, 32'h0);
    run_cmd("prio_a_n", 1'b0, 1'b1, 1'b1, jdo_a(1'b1, 8'h40), 0, 32'h7777_8888, 3);
    check("prio_a_n_data", MonDReg, 32'h7777_8888);

    // write beats address load: addr is not reloaded from jdo
    push_exp(1'b1, 8'h41, 32'h0F0F_0F0F);
    run_cmd("prio_b_a", 1'b1, 1'b1, 1'b0, jdo_b(32'h0F0F_0F0F), 0, 32'h0, 3);
    push_exp(1'b0, 8'h42, 32'h0);
    run_cmd("prio_b_a_next", 1'b0, 1'b0, 1'b1, '0, 0, 32'h9999_AAAA, 3);

    // ack while IDLE is ignored
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_data", MonDReg, 32'h9999_AAAA);
    check("stray_ack_ready", {31'b0, monitor_ready}, 32'd1);

    // reset in WAIT: request drops at once, late ack is ignored
    push_exp(1'b0, 8'h43, 32'h0);
    ack_delay = -1;
    pulse(1'b0, 1'b0, 1'b1, '0);
    repeat (3) @(negedge clk);
    check("pre_reset_req", {31'b0, mem_bus.mem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("async_rst_ready", {31'b0, monitor_ready}, 32'd1);
    check("async_rst_addr", {24'b0, mem_bus.mem_addr}, 32'd0);
    check("async_rst_mondreg", MonDReg, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    check("late_ack_mondreg", MonDReg, 32'd0);
    check("late_ack_req", {31'b0, mem_bus.mem_req}, 32'd0);

    // address restarted from 0 after reset
    push_exp(1'b0, 8'h00, 32'h0);
    run_cmd("post_reset", 1'b0, 1'b0, 1'b1, '0, 0, 32'h55AA_55AA, 3);
    check("post_reset_data", MonDReg, 32'h55AA_55AA);

    repeat (2) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case a wait never resolves
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, limit 200000", $time);
    $fatal(1);
  end

endmodule
